fifo_drain: RTL and testbench
=============================

# fifo_drain

Read-side engine for the team's synchronous FIFO. It watches `fifo_empty`, issues single-cycle `re` pulses and captures the FIFO's `data_out`. Each word is re-presented on a valid/ready stream with optional packet framing (`m_last`). It sits between the FIFO and any downstream consumer, such as a serializer or bus master.

## Interface
- `width`, 16, data word width; must match the FIFO's `width`.
- `len_width`, 8, width of the packet-length input and the internal word counter.
- `clk`  input  1  rising-edge clock shared with the FIFO.
- `rst`  input  1  asynchronous, active-high reset.
- `en`  input  1  drain enable; when low, no new pop starts.
- `pkt_len`  input  len_width  words per packet; 0 = unframed.
- `fifo_empty`  input  1  from FIFO.
- `fifo_data`  input  width  FIFO `data_out`.
- `re`  output  1  FIFO read strobe, one cycle per word.
- `m_data`  output  width  output word.
- `m_valid`  output  1  `m_data` holds a word.
- `m_ready`  input  1  consumer accepts the word.
- `m_last`  output  1  final word of a packet; qualified by `m_valid`.
- `busy`  output  1  high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE: `re`=0, `m_valid`=0. If `en` && !`fifo_empty`, go to POP.
  - POP: `re`=1 for exactly this cycle. Next state is WAIT.
  - WAIT: register `fifo_data` into `m_data` at the end of this cycle. Next state is VALID.
  - VALID: `m_valid`=1; `m_data` and `m_last` are held stable.
    - On `m_ready`, if `en` && !`fifo_empty`, go to POP; otherwise go to IDLE.
    - Without `m_ready`, stay in VALID indefinitely.
- FIFO read contract: the FIFO presents the popped word on `fifo_data` in the cycle after `re`.
- `re` is a registered state decode. It is never asserted while `fifo_empty`=1 is sampled, so the FIFO cannot underflow.
- Framing:
  - `pkt_len` is sampled into a holding register on the first pop of each packet (word count = 0).
  - A change to `pkt_len` mid-packet has no effect on the current packet.
  - `m_last` = (word count == latched `pkt_len` − 1) when the latched length is nonzero. It is always 0 when the latched length is 0.
  - The word count increments on each `m_valid && m_ready` handshake. It returns to 0 after a handshake with `m_last`=1.
  - Arithmetic is unsigned, modulo 2^`len_width`.
- `en` deassertion mid-word: the POP/WAIT/VALID sequence completes and the word is delivered. The FSM then parks in IDLE with the packet count preserved.
- Reset mid-operation: all state clears. A word already popped but not yet accepted is discarded; the system owner resets the FIFO together with this block.

## Timing
- Reset values: `re`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `busy`=0, state=IDLE, word count=0, latched length=0.
- Latency from `fifo_empty` falling (with `en`=1, in IDLE) to `m_valid`: 3 cycles (IDLE→POP→WAIT→VALID).
- Sustained throughput with `m_ready` held high and the FIFO non-empty: one word every 3 cycles.
- All outputs are registered; there is no combinational path from `m_ready` or `fifo_empty` to any output.
- Handshake occurs on any rising edge with `m_valid`=1 and `m_ready`=1. `m_ready` may be high before `m_valid` is raised.

## Configuration
- `FIFO_DRAIN_PARITY_EN` defined:
  - Adds output `m_parity`, 1 bit, equal to the XOR of all `m_data` bits (even parity).
  - It is registered with `m_data`, held with it, and resets to 0.
- `FIFO_DRAIN_PARITY_EN` undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `fifo_drain_pkg`:
  - state encoding constants (IDLE, POP, WAIT, VALID; 2 bits);
  - default `width`/`len_width` constants used by the top-level FIFO and this block.
- One sub-module `pkt_counter`:
  - clear, increment and terminal-count compare for the word count;
  - produces `m_last` from the latched length.
- The FSM and the data register live in `fifo_drain`.

## Test plan
- Reset: assert `rst` asynchronously mid-VALID with `m_data`=16'hBEEF → all outputs 0 immediately. No `re` until `rst` releases and `fifo_empty`=0.
- Single word: FIFO holds 16'hA5A5, `m_ready`=1, `pkt_len`=0 → one `re` pulse. `m_valid` rises 3 cycles after start with `m_data`=16'hA5A5 and `m_last`=0, then returns to IDLE.
- Backpressure: 3 words queued, `m_ready` low for 10 cycles → `m_data` stable and exactly one `re` issued. On release, the remaining two words follow at 3-cycle spacing.
- Framing: `pkt_len`=3, 7 words pushed → `m_last` on words 3 and 6. `pkt_len` changed to 5 after word 1 has no effect until word 4.
- Enable/empty boundary: drop `en` during POP → the word completes and no further `re` occurs. `fifo_empty` rises in the same cycle as the handshake → the FSM returns to IDLE, `re` stays 0.
- Parity (macro defined): `m_data`=16'h0001 → `m_parity`=1; 16'h0003 → `m_parity`=0.

Source files
------------

// File: rtl/fifo_drain_pkg.sv
// rtl/fifo_drain_pkg.sv - shared state encoding and default sizes for the FIFO read-side engine
package fifo_drain_pkg;

   localparam int DEF_WIDTH     = 16;
   localparam int DEF_LEN_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      POP   = 2'd1,
      WAIT  = 2'd2,
      VALID = 2'd3
   } state_t;

endpackage

// File: rtl/fifo_drain_pkt_counter.sv
// rtl/fifo_drain_pkt_counter.sv - pkt_counter: per-packet word count, length latch and last-word flag
module pkt_counter
   import fifo_drain_pkg::*;
#(
   parameter int len_width = DEF_LEN_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pop,
   input  logic                 hs,
   input  logic [len_width-1:0] pkt_len,
   output logic                 last
);

   logic [len_width-1:0] count;
   logic [len_width-1:0] len_q;
   logic                 first_word;

   assign first_word = (count == '0);
   assign last       = (len_q != '0) && (count == len_q - 1'b1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         len_q <= '0;
      end else begin
         if (pop && first_word) begin
            len_q <= pkt_len;
         end
         // Unframed words keep the count at 0 so a new length is picked up on the next pop.
         if (hs) begin
            if (last || (len_q == '0)) begin
               count <= '0;
            end else begin
               count <= count + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/fifo_drain.sv
// rtl/fifo_drain.sv - FIFO read engine re-presenting words on a valid/ready stream; FIFO_DRAIN_PARITY_EN adds m_parity
module fifo_drain
   import fifo_drain_pkg::*;
#(
   parameter int width     = DEF_WIDTH,
   parameter int len_width = DEF_LEN_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [len_width-1:0] pkt_len,
   input  logic                 fifo_empty,
   input  logic [width-1:0]     fifo_data,
   output logic                 re,
   output logic [width-1:0]     m_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic                 m_last,
`ifdef FIFO_DRAIN_PARITY_EN
   output logic                 m_parity,
`endif
   output logic                 busy
);

   state_t state_q;
   state_t state_d;
   logic   can_pop;
   logic   hs;

   assign can_pop = en && !fifo_empty;
   assign hs      = (state_q == VALID) && m_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (can_pop) state_d = POP;
         POP:     state_d = WAIT;
         WAIT:    state_d = VALID;
         VALID: begin
            if (m_ready) begin
               state_d = can_pop ? POP : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decode the state register only, so nothing combinational reaches them from inputs.
   assign re      = (state_q == POP);
   assign m_valid = (state_q == VALID);
   assign busy    = (state_q != IDLE);

   // The FIFO drives the popped word during WAIT, one cycle after re.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_data <= '0;
      end else if (state_q == WAIT) begin
         m_data <= fifo_data;
      end
   end

`ifdef FIFO_DRAIN_PARITY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_parity <= 1'b0;
      end else if (state_q == WAIT) begin
         m_parity <= ^fifo_data;
      end
   end
`endif

   pkt_counter #(
      .len_width (len_width)
   ) u_pkt_counter (
      .clk     (clk),
      .rst     (rst),
      .pop     (re),
      .hs      (hs),
      .pkt_len (pkt_len),
      .last    (m_last)
   );

endmodule

// File: tb/tb_fifo_drain.sv
// tb/tb_fifo_drain.sv - directed self-checking bench for fifo_drain with a behavioural FIFO model
module tb_fifo_drain;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [7:0]  pkt_len;
   logic        fifo_empty;
   logic [15:0] fifo_data = '0;
   logic        re;
   logic [15:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic        m_last;
   logic        busy;
`ifdef FIFO_DRAIN_PARITY_EN
   logic        m_parity;
`endif

   logic [15:0] mem [0:63];
   int          push_cnt = 0;
   int          pop_cnt  = 0;
   int          re_cnt   = 0;
   logic        empty_ovr;
   int          vectors  = 0;
   int          miscompares = 0;
   int          base;

   always #5 clk = ~clk;

   fifo_drain dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .pkt_len    (pkt_len),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .re         (re),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_last     (m_last),
`ifdef FIFO_DRAIN_PARITY_EN
      .m_parity   (m_parity),
`endif
      .busy       (busy)
   );

   // FIFO model: word appears on fifo_data the cycle after re; reset flushes it.
   assign fifo_empty = (push_cnt == pop_cnt) || empty_ovr;

   always @(posedge clk) begin
      if (rst) begin
         pop_cnt <= push_cnt;
      end else if (re) begin
         fifo_data <= mem[pop_cnt[5:0]];
         pop_cnt   <= pop_cnt + 1;
      end
   end

   always @(posedge clk) if (re && !rst) re_cnt++;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] w);
      mem[push_cnt[5:0]] = w;
      push_cnt = push_cnt + 1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input string tag);
      for (int i = 0; i < 12 && !m_valid; i++) step();
      chk(tag, {31'd0, m_valid}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; en = 1'b0; pkt_len = 8'd0; m_ready = 1'b0; empty_ovr = 1'b0;
      step(); step();
      chk("rst_re",     {31'd0, re},      32'd0);
      chk("rst_valid",  {31'd0, m_valid}, 32'd0);
      chk("rst_last",   {31'd0, m_last},  32'd0);
      chk("rst_data",   {16'd0, m_data},  32'd0);
      chk("rst_busy",   {31'd0, busy},    32'd0);
      rst = 1'b0;
      step();

      // single word, 3-cycle latency
      base = re_cnt;
      push(16'hA5A5); en = 1'b1; m_ready = 1'b1;
      step(); chk("single_re",     {31'd0, re},      32'd1);
      step(); chk("single_re_off", {31'd0, re},      32'd0);
              chk("single_nv",     {31'd0, m_valid}, 32'd0);
      step(); chk("single_valid",  {31'd0, m_valid}, 32'd1);
              chk("single_data",   {16'd0, m_data},  32'h0000A5A5);
              chk("single_last",   {31'd0, m_last},  32'd0);
      step(); chk("single_idle",   {31'd0, busy},    32'd0);
              chk("single_recnt",  re_cnt - base,    32'd1);

      // backpressure
      base = re_cnt; m_ready = 1'b0;
      push(16'h1111); push(16'h2222); push(16'h3333);
      step(); step(); step();
      chk("bp_valid", {31'd0, m_valid}, 32'd1);
      repeat (10) step();
      chk("bp_data_held", {16'd0, m_data}, 32'h00001111);
      chk("bp_valid_held", {31'd0, m_valid}, 32'd1);
      chk("bp_one_re", re_cnt - base, 32'd1);
      m_ready = 1'b1;
      step(); chk("bp_re2", {31'd0, re}, 32'd1);
      step(); step();
      chk("bp_data2", {16'd0, m_data}, 32'h00002222);
      chk("bp_valid2", {31'd0, m_valid}, 32'd1);
      step(); chk("bp_re3", {31'd0, re}, 32'd1);
      step(); step();
      chk("bp_data3", {16'd0, m_data}, 32'h00003333);
      step(); chk("bp_idle", {31'd0, busy}, 32'd0);
      chk("bp_recnt", re_cnt - base, 32'd3);

      // framing, pkt_len=3, last on words 3 and 6
      pkt_len = 8'd3;
      for (int i = 0; i < 7; i++) push(16'h0100 + 16'(i));
      for (int i = 0; i < 7; i++) begin
         wait_valid("fr1_valid");
         chk("fr1_data", {16'd0, m_data}, 32'h00000100 + i);
         chk("fr1_last", {31'd0, m_last}, (i % 3 == 2) ? 32'd1 : 32'd0);
         step();
      end

      // asynchronous reset mid-VALID
      m_ready = 1'b0;
      push(16'hBEEF);
      wait_valid("rst_mid_valid");
      chk("rst_mid_data", {16'd0, m_data}, 32'h0000BEEF);
      #2 rst = 1'b1;
      #1;
      chk("arst_re",    {31'd0, re},      32'd0);
      chk("arst_valid", {31'd0, m_valid}, 32'd0);
      chk("arst_last",  {31'd0, m_last},  32'd0);
      chk("arst_data",  {16'd0, m_data},  32'd0);
      chk("arst_busy",  {31'd0, busy},    32'd0);
      push(16'h7777);
      step(); chk("arst_no_re", {31'd0, re}, 32'd0);
      rst = 1'b0;
      step(); chk("post_rst_re", {31'd0, re}, 32'd0);
              chk("post_rst_busy", {31'd0, busy}, 32'd0);
      step(); chk("post_rst_re2", {31'd0, re}, 32'd0);

      // framing with mid-packet length change
      pkt_len = 8'd3; m_ready = 1'b1;
      for (int i = 0; i < 8; i++) push(16'h0200 + 16'(i));
      for (int i = 0; i < 8; i++) begin
         wait_valid("fr2_valid");
         chk("fr2_data", {16'd0, m_data}, 32'h00000200 + i);
         chk("fr2_last", {31'd0, m_last}, (i == 2 || i == 7) ? 32'd1 : 32'd0);
         step();
         if (i == 0) pkt_len = 8'd5;
      end

      // en dropped during POP
      pkt_len = 8'd0; base = re_cnt;
      push(16'h0301); push(16'h0302);
      step(); chk("en_pop_re", {31'd0, re}, 32'd1);
      en = 1'b0;
      step(); step();
      chk("en_data", {16'd0, m_data}, 32'h00000301);
      chk("en_valid", {31'd0, m_valid}, 32'd1);
      step(); chk("en_idle", {31'd0, busy}, 32'd0);
      step(); step();
      chk("en_no_re", re_cnt - base, 32'd1);

      // fifo_empty rises in the handshake cycle
      push(16'h0303);
      m_ready = 1'b0; en = 1'b1; base = re_cnt;
      step(); step(); step();
      chk("emp_data", {16'd0, m_data}, 32'h00000302);
      m_ready = 1'b1; empty_ovr = 1'b1;
      step(); chk("emp_idle", {31'd0, busy}, 32'd0);
              chk("emp_nv", {31'd0, m_valid}, 32'd0);
      step(); step();
      chk("emp_no_re", re_cnt - base, 32'd1);
      empty_ovr = 1'b0;
      wait_valid("emp_drain_valid");
      chk("emp_drain_data", {16'd0, m_data}, 32'h00000303);
      step();

`ifdef FIFO_DRAIN_PARITY_EN
      m_ready = 1'b0;
      push(16'h0001);
      wait_valid("par1_valid");
      chk("par1", {31'd0, m_parity}, 32'd1);
      m_ready = 1'b1; step(); m_ready = 1'b0;
      push(16'h0003);
      wait_valid("par0_valid");
      chk("par0", {31'd0, m_parity}, 32'd0);
      m_ready = 1'b1; step();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
